ra_sample_source: RTL and testbench

- Transmit-side counterpart of the rolling-average input interface: drives the data strobe and sample value that the averager consumes.
- Holds a small pattern buffer loaded from the host side, then replays it as strobed samples with programmable timing, once or repeating.
- Used as an on-chip stimulus source for the rolling-average top and its cocotb bench.

---
 rtl/ra_pkg.sv | 23 ++
 rtl/ra_sample_source_if.sv | 39 +++
 rtl/ra_phase_timer.sv | 27 ++
 rtl/ra_sample_source.sv | 189 ++++++++++++++++++
 tb/tb_ra_sample_source.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ra_pkg.sv
// Shared constants for the rolling-average sample source: FSM state codes,
// default sample width and the 16-bit Fibonacci LFSR used for pseudo-random stimulus.
package ra_pkg;

    localparam int DEF_BITS_PER_ELEM = 5;

    typedef logic [2:0] ra_state_t;

    localparam ra_state_t ST_IDLE  = 3'd0;
    localparam ra_state_t ST_SETUP = 3'd1;
    localparam ra_state_t ST_HIGH  = 3'd2;
    localparam ra_state_t ST_LOW   = 3'd3;
    localparam ra_state_t ST_DONE  = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting register map to bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/ra_sample_source_if.sv
// Host/averager-facing signal bundle of the sample source.
// RA_SAMPLE_SOURCE_LFSR_EN adds the i_lfsr_mode control.
interface ra_sample_source_if #(
    parameter int BITS_PER_ELEM = ra_pkg::DEF_BITS_PER_ELEM,
    parameter int DIV_WIDTH     = 4
);
    logic                     i_load;
    logic [BITS_PER_ELEM-1:0] i_load_value;
    logic                     i_clear;
    logic                     i_start;
    logic                     i_stop;
    logic                     i_repeat;
    logic [DIV_WIDTH-1:0]     i_div;
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
    logic                     i_lfsr_mode;
`endif
    logic                     o_data_clk;
    logic [BITS_PER_ELEM-1:0] o_value;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_full;

    modport master (
        input  i_load, i_load_value, i_clear, i_start, i_stop, i_repeat, i_div,
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        input  i_lfsr_mode,
`endif
        output o_data_clk, o_value, o_busy, o_done, o_full
    );

    modport slave (
        output i_load, i_load_value, i_clear, i_start, i_stop, i_repeat, i_div,
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        output i_lfsr_mode,
`endif
        input  o_data_clk, o_value, o_busy, o_done, o_full
    );

endinterface

// File: rtl/ra_phase_timer.sv
// Loadable down-counter shared by the SETUP/HIGH/LOW phases; tc is high on
// the final cycle of a phase (count of zero).
module ra_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/ra_sample_source.sv
// Pattern-buffer sample source that replays stored values as strobed samples.
// RA_SAMPLE_SOURCE_LFSR_EN enables an LFSR sample mode that bypasses the buffer.
//
// state | meaning
// IDLE  | buffer load/clear accepted, waiting for start
// SETUP | o_value settling, strobe low, div+1 cycles
// HIGH  | strobe high, div+1 cycles
// LOW   | strobe low, div+1 cycles; decides next sample or finish
// DONE  | single cycle, o_done pulse
module ra_sample_source
    import ra_pkg::*;
#(
    parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
    parameter int DEPTH         = 8,
    parameter int DIV_WIDTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    ra_sample_source_if.master  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BITS_PER_ELEM-1:0] buf_mem [DEPTH];

    ra_state_t                state;
    logic [CNT_W-1:0]         count;
    logic [PTR_W-1:0]         rd;
    logic [PTR_W-1:0]         rd_next;
    logic [DIV_WIDTH-1:0]     div_q;
    logic                     rep_q;
    logic                     stop_pend;

    logic                     data_clk_q;
    logic [BITS_PER_ELEM-1:0] value_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     full_q;

    logic                     start_ok;
    logic                     load_ok;
    logic                     at_last_ptr;
    logic                     last;
    logic                     finish;
    logic                     advance;
    logic                     tmr_load;
    logic [DIV_WIDTH-1:0]     tmr_val;
    logic                     tc;
    logic [BITS_PER_ELEM-1:0] first_sample;
    logic [BITS_PER_ELEM-1:0] next_sample;

`ifdef RA_SAMPLE_SOURCE_LFSR_EN
    logic [15:0]              lfsr;
    logic                     lfsr_mode_q;
`endif

    always_comb begin
        start_ok = bus.i_start && (count != '0);
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        start_ok = bus.i_start && ((count != '0) || bus.i_lfsr_mode);
`endif
        load_ok     = (state == ST_IDLE) && !start_ok && !bus.i_clear && bus.i_load &&
                      (count != CNT_W'(DEPTH));
        at_last_ptr = (CNT_W'(rd) == count - 1'b1);
        // An empty buffer only plays in LFSR mode, where rd is irrelevant.
        rd_next     = ((count == '0) || at_last_ptr) ? '0 : rd + 1'b1;
        last        = (count != '0) && at_last_ptr && !rep_q;
        finish      = stop_pend || bus.i_stop || last;
        advance     = (state == ST_LOW) && tc && !finish;
        tmr_load    = ((state == ST_IDLE) && start_ok) ||
                      (tc && ((state == ST_SETUP) || (state == ST_HIGH) || (state == ST_LOW)));
        tmr_val     = (state == ST_IDLE) ? bus.i_div : div_q;
        first_sample = buf_mem[0];
        next_sample  = buf_mem[rd_next];
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        if (bus.i_lfsr_mode) first_sample = LFSR_SEED[BITS_PER_ELEM-1:0];
        if (lfsr_mode_q)     next_sample  = lfsr[BITS_PER_ELEM-1:0];
`endif
    end

    ra_phase_timer #(
        .WIDTH    (DIV_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

    // Buffer contents survive reset; only the write count is cleared.
    always_ff @(posedge clk) begin
        if (!rst && load_ok) begin
            buf_mem[count[PTR_W-1:0]] <= bus.i_load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            rd         <= '0;
            div_q      <= '0;
            rep_q      <= 1'b0;
            stop_pend  <= 1'b0;
            data_clk_q <= 1'b0;
            value_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state != ST_IDLE) && bus.i_stop) stop_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        div_q     <= bus.i_div;
                        rep_q     <= bus.i_repeat;
                        rd        <= '0;
                        value_q   <= first_sample;
                        busy_q    <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= ST_SETUP;
                    end else if (bus.i_clear) begin
                        count  <= '0;
                        full_q <= 1'b0;
                    end else if (load_ok) begin
                        count  <= count + 1'b1;
                        full_q <= ((count + 1'b1) == CNT_W'(DEPTH));
                    end
                end
                ST_SETUP: begin
                    if (tc) begin
                        data_clk_q <= 1'b1;
                        state      <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        data_clk_q <= 1'b0;
                        state      <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tc) begin
                        if (finish) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            rd      <= rd_next;
                            value_q <= next_sample;
                            state   <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q    <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RA_SAMPLE_SOURCE_LFSR_EN
    // The start sample consumes the seed, so the register already holds the
    // following value when SETUP is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr        <= LFSR_SEED;
            lfsr_mode_q <= 1'b0;
        end else if ((state == ST_IDLE) && start_ok) begin
            lfsr_mode_q <= bus.i_lfsr_mode;
            lfsr        <= bus.i_lfsr_mode ? lfsr_next(LFSR_SEED) : LFSR_SEED;
        end else if (advance && lfsr_mode_q) begin
            lfsr <= lfsr_next(lfsr);
        end
    end
`endif

    assign bus.o_data_clk = data_clk_q;
    assign bus.o_value    = value_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_full     = full_q;

endmodule

// File: tb/tb_ra_sample_source.sv
// Scoreboard bench for ra_sample_source: a stimulus process queues the samples
// the buffer model predicts, a negedge monitor checks every strobe against them.
module tb_ra_sample_source;

    localparam int BW    = 5;
    localparam int DEPTH = 8;
    localparam int DW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ra_sample_source_if #(.BITS_PER_ELEM(BW), .DIV_WIDTH(DW)) bus();

    ra_sample_source #(
        .BITS_PER_ELEM (BW),
        .DEPTH         (DEPTH),
        .DIV_WIDTH     (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int mbuf[$];

    int cur_div   = 0;
    bit new_run   = 1'b0;
    int mon_cyc   = 0;
    int last_rise = 0;
    int high_len  = 0;
    int hold_val  = 0;
    bit prev_dc   = 1'b0;
    bit unstable  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_step(input int s);
        int b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return ((s >> 1) | (b << 15)) & 32'h0000_FFFF;
    endfunction

    // Monitor: value at each rising strobe, strobe width, period, stability.
    always @(negedge clk) begin
        mon_cyc++;
        if (rst) begin
            prev_dc = 1'b0;
        end else begin
            if (bus.o_data_clk && !prev_dc) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got value %0d, expected no strobe", bus.o_value);
                end else begin
                    check("sample_value", bus.o_value, exp_q.pop_front());
                end
                if (!new_run) check("strobe_period", mon_cyc - last_rise, 3 * (cur_div + 1));
                new_run   = 1'b0;
                last_rise = mon_cyc;
                high_len  = 1;
                hold_val  = bus.o_value;
                unstable  = 1'b0;
            end else if (bus.o_data_clk) begin
                high_len++;
                if (bus.o_value !== hold_val[BW-1:0]) unstable = 1'b1;
            end else if (prev_dc) begin
                check("strobe_high_len", high_len, cur_div + 1);
                check("value_stable", unstable, 0);
            end
            prev_dc = bus.o_data_clk;
        end
    end

    task automatic load_val(input int v);
        @(posedge clk); #1;
        bus.i_load       = 1'b1;
        bus.i_load_value = v[BW-1:0];
        @(posedge clk); #1;
        bus.i_load = 1'b0;
        if (mbuf.size() < DEPTH) mbuf.push_back(v & 31);
        check("full_flag", bus.o_full, mbuf.size() == DEPTH);
    endtask

    task automatic clear_buf(input bit with_load);
        @(posedge clk); #1;
        bus.i_clear      = 1'b1;
        bus.i_load       = with_load;
        bus.i_load_value = 5'd17;
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
        bus.i_load  = 1'b0;
        mbuf.delete();
        check("full_after_clear", bus.o_full, 0);
    endtask

    task automatic play(input int div, input bit rep, input int stop_at, input bit lfsr, input bit junk);
        int n, cyc, rises, s, budget;
        bit seen_done, pdc, stop_sent;
        n = (stop_at > 0) ? stop_at : mbuf.size();
        s = 32'h0000_ACE1;
        for (int i = 0; i < n; i++) begin
            if (lfsr) begin
                exp_q.push_back(s & 31);
                s = lfsr_step(s);
            end else begin
                exp_q.push_back(mbuf[i % mbuf.size()]);
            end
        end
        cur_div = div;
        new_run = 1'b1;
        @(posedge clk); #1;
        bus.i_start  = 1'b1;
        bus.i_div    = div[DW-1:0];
        bus.i_repeat = rep;
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        bus.i_lfsr_mode = lfsr;
`endif
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        cyc = -1; rises = 0; pdc = 1'b0; stop_sent = 1'b0; seen_done = 1'b0;
        budget = n * 3 * (div + 1) + 8;
        while (!seen_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.o_data_clk && !pdc) begin
                rises++;
                if (rises == stop_at) begin
                    bus.i_stop = 1'b1;
                    stop_sent  = 1'b1;
                end
            end else if (stop_sent) begin
                bus.i_stop = 1'b0;
            end
            if (junk && cyc == 1) begin
                bus.i_load       = 1'b1;
                bus.i_load_value = 5'd30;
            end
            if (junk && cyc == 2) begin
                bus.i_load  = 1'b0;
                bus.i_clear = 1'b1;
            end
            if (junk && cyc == 3) bus.i_clear = 1'b0;
            pdc = bus.o_data_clk;
            if (bus.o_done) seen_done = 1'b1;
        end
        bus.i_stop = 1'b0;
        check("done_seen", seen_done, 1);
        if (seen_done) begin
            check("done_cycle", cyc, n * 3 * (div + 1));
            check("busy_in_done", bus.o_busy, 1);
        end
        @(negedge clk);
        check("done_one_cycle", bus.o_done, 0);
        check("busy_after_done", bus.o_busy, 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        bus.i_lfsr_mode = 1'b0;
`endif
    endtask

    task automatic start_expect_idle(input string name);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        check(name, {bus.o_busy, bus.o_data_clk, bus.o_done}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, dv, st, got;
        bit rp;
        bus.i_load = 1'b0; bus.i_load_value = '0; bus.i_clear = 1'b0;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_repeat = 1'b0; bus.i_div = '0;
`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        bus.i_lfsr_mode = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.o_data_clk, bus.o_value, bus.o_busy, bus.o_done, bus.o_full}, 0);
        rst = 1'b0;

        // Basic three-sample playback, fastest timing.
        load_val(3); load_val(7); load_val(31);
        play(0, 1'b0, 0, 1'b0, 1'b0);

        // Full buffer; ninth load ignored; clear wins over a simultaneous load.
        clear_buf(1'b0);
        for (int i = 0; i < 8; i++) load_val(10 + i);
        load_val(20);
        play(0, 1'b0, 0, 1'b0, 1'b0);
        clear_buf(1'b1);

        // Repeat with a stop raised during the fifth strobe.
        load_val(1); load_val(2);
        play(3, 1'b1, 5, 1'b0, 1'b0);

        // Empty buffer ignores start.
        clear_buf(1'b0);
        start_expect_idle("start_empty_ignored");

        // Loads and clears during playback leave the buffer untouched.
        load_val(4); load_val(9);
        play(1, 1'b0, 0, 1'b0, 1'b1);
        play(0, 1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of a HIGH phase.
        clear_buf(1'b0);
        for (int i = 0; i < 8; i++) load_val(21 - i);
        for (int i = 0; i < 8; i++) exp_q.push_back(mbuf[i]);
        cur_div = 2;
        new_run = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_div = 4'd2; bus.i_repeat = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (bus.o_data_clk) got = 1;
        end
        check("reset_wait_strobe", got, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_reset_outputs", {bus.o_data_clk, bus.o_value, bus.o_busy, bus.o_done, bus.o_full}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mbuf.delete();
        start_expect_idle("start_after_reset_count0");

`ifdef RA_SAMPLE_SOURCE_LFSR_EN
        // LFSR mode with an empty buffer runs until stopped.
        play(0, 1'b0, 6, 1'b1, 1'b0);
        play(2, 1'b0, 3, 1'b1, 1'b0);
`endif

        // Randomised buffer contents, timing, repeat and stop position.
        for (int it = 0; it < 15; it++) begin
            clear_buf(1'b0);
            nl = $urandom_range(1, DEPTH);
            for (int i = 0; i < nl; i++) load_val($urandom_range(0, 31));
            dv = $urandom_range(0, 3);
            rp = 1'($urandom_range(0, 1));
            if (rp) st = $urandom_range(1, 2 * nl + 1);
            else    st = ($urandom_range(0, 1) != 0) ? $urandom_range(1, nl) : 0;
            play(dv, rp, st, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
